// File: rtl/dyn_array_if.sv
// Append and read-out stream bundle for dyn_array_reader.
// master: the array block (accepts appends, drives elements); slave: its environment.
interface dyn_array_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 4
);
  logic             wr_valid;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_ready;

  modport master (
    input  wr_valid, wr_data, out_ready,
    output wr_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    output wr_valid, wr_data, out_ready,
    input  wr_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/dyn_array_reader.sv
// Dynamic-array model: append-only storage, .size()/.delete(), and a valid/ready read-out.
// Optional DYN_ARRAY_READER_REVERSE_EN adds a 'rev' input for descending read-out.
module dyn_array_reader #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        del,
  input  logic        start,
`ifdef DYN_ARRAY_READER_REVERSE_EN
  input  logic        rev,
`endif
  output logic [31:0] size_o,
  output logic        busy,
  output logic        done,
  dyn_array_if.master bus
);
  localparam int unsigned IDX_W = $clog2(MAX_DEPTH);
  localparam int unsigned SZ_W  = IDX_W + 1;

  typedef enum logic {IDLE, READ} state_t;

  state_t           state;
  logic [SZ_W-1:0]  size;
  logic [SZ_W-1:0]  size_m1;
  logic [IDX_W-1:0] rd_idx;
  logic             dir_rev;
  logic             rev_in;
  logic             last;
  logic             wr_fire;
  logic [WIDTH-1:0] mem [MAX_DEPTH];

`ifdef DYN_ARRAY_READER_REVERSE_EN
  assign rev_in = rev;
`else
  assign rev_in = 1'b0;
`endif

  assign size_m1     = size - SZ_W'(1);
  assign bus.wr_ready = (state == IDLE) && (size < SZ_W'(MAX_DEPTH)) && !del && !start;
  assign wr_fire     = bus.wr_valid && bus.wr_ready;

  // Final element is index 0 when descending, size-1 when ascending.
  assign last = dir_rev ? (rd_idx == '0) : ({1'b0, rd_idx} == size_m1);

  assign bus.out_valid = (state == READ);
  assign bus.out_data  = bus.out_valid ? mem[rd_idx] : '0;
  assign bus.out_idx   = bus.out_valid ? rd_idx : '0;
  assign bus.out_last  = bus.out_valid && last;
  assign busy          = (state == READ);
  assign size_o        = 32'(size);

  // Storage is deliberately not reset; only written locations are ever read.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[size[IDX_W-1:0]] <= bus.wr_data;
  end

  // Control FSM; del overrides every other event in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      size    <= '0;
      rd_idx  <= '0;
      dir_rev <= 1'b0;
      done    <= 1'b0;
    end else if (del) begin
      state  <= IDLE;
      size   <= '0;
      rd_idx <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_fire) size <= size + SZ_W'(1);
          if (start) begin
            if (size != '0) begin
              state   <= READ;
              dir_rev <= rev_in;
              rd_idx  <= rev_in ? size_m1[IDX_W-1:0] : '0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        READ: begin
          if (bus.out_ready) begin
            if (last) begin
              state  <= IDLE;
              rd_idx <= '0;
              done   <= 1'b1;
            end else begin
              rd_idx <= dir_rev ? rd_idx - IDX_W'(1) : rd_idx + IDX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
